// File: rtl/uart_pkg.sv
// Types shared between the UART TX and RX controllers.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_9600,
    BAUD_19200,
    BAUD_57600,
    BAUD_115200
  } baud_set_t;

endpackage

// File: rtl/uart_rx_controller.sv
// UART receiver: 16x oversampling, 3-sample majority vote, LSB-first word.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int F_CLK             = 16000000
) (
  input  logic                         clk_16mhz,
  input  logic                         rstn,
  input  logic                         serial_in,
  input  baud_set_t                    baud_setting,
  output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                         rx_valid,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         rx_busy
);

  localparam int DIV_W = 16;
  localparam int BIT_W = (OUTPUT_DATA_WIDTH > 1) ? $clog2(OUTPUT_DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUTPUT_DATA_WIDTH - 1);

  // Rounded divisors: (F + 8*baud) / (16*baud) == round(F / (16*baud))
  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'((F_CLK + 8 * 9600)   / (16 * 9600));
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'((F_CLK + 8 * 19200)  / (16 * 19200));
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'((F_CLK + 8 * 57600)  / (16 * 57600));
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'((F_CLK + 8 * 115200) / (16 * 115200));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  logic                         r_sync1;
  logic                         r_sync2;
  logic                         r_rx_prev;
  logic                         w_rx_s;
  logic                         w_fall;

  state_t                       r_state;
  logic [DIV_W-1:0]             r_div;
  logic [DIV_W-1:0]             r_div_cnt;
  logic [3:0]                   r_os_idx;
  logic [BIT_W-1:0]             r_bit_cnt;
  logic                         r_s7;
  logic                         r_s8;
  logic [OUTPUT_DATA_WIDTH-1:0] r_shift;
  logic [OUTPUT_DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_ferr;
  logic                         r_busy;
`ifdef UART_RX_PARITY_EN
  logic                         r_par;
  logic                         r_perr;
`endif

  logic [DIV_W-1:0]             w_div_sel;
  logic                         w_tick;
  logic                         w_decide;
  logic                         w_bit_end;
  logic                         w_maj;

  assign w_rx_s    = r_sync2;
  assign w_fall    = r_rx_prev & ~r_sync2;
  assign w_tick    = (r_div_cnt == r_div - DIV_W'(1));
  assign w_decide  = w_tick && (r_os_idx == 4'd9);
  assign w_bit_end = w_tick && (r_os_idx == 4'd15);
  // Sample 9 is the live line value on the deciding tick
  assign w_maj     = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);

  always_comb begin
    w_div_sel = DIV_9600;
    case (baud_setting)
      BAUD_9600:   w_div_sel = DIV_9600;
      BAUD_19200:  w_div_sel = DIV_19200;
      BAUD_57600:  w_div_sel = DIV_57600;
      BAUD_115200: w_div_sel = DIV_115200;
      default:     w_div_sel = DIV_9600;
    endcase
  end

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= serial_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge clk_16mhz or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_os_idx  <= '0;
      r_bit_cnt <= '0;
      r_s7      <= 1'b0;
      r_s8      <= 1'b0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      if (r_state == ST_IDLE) begin
        // Counters sit cleared in IDLE so a start edge begins at os_idx 0
        r_div     <= w_div_sel;
        r_div_cnt <= '0;
        r_os_idx  <= '0;
        if (w_fall) begin
          r_state <= ST_START;
          r_busy  <= 1'b1;
        end
      end else begin
        if (w_tick) begin
          r_div_cnt <= '0;
          r_os_idx  <= r_os_idx + 4'd1;
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
        if (w_tick && (r_os_idx == 4'd7)) r_s7 <= w_rx_s;
        if (w_tick && (r_os_idx == 4'd8)) r_s8 <= w_rx_s;

        case (r_state)
          ST_START: begin
            if (w_decide && w_maj) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_bit_end) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (w_decide) r_shift[r_bit_cnt] <= w_maj;
            if (w_bit_end) begin
              if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (w_decide)  r_par   <= w_maj;
            if (w_bit_end) r_state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed
            if (w_decide) begin
              r_data  <= r_shift;
              r_valid <= w_maj;
              r_ferr  <= ~w_maj;
`ifdef UART_RX_PARITY_EN
              r_perr  <= (^r_shift) ^ r_par;
`endif
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out  = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy   = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomized bench for uart_rx_controller: drives ideal UART frames and
// compares every output pulse against frame-level expectations.
module tb_uart_rx_controller;
  import uart_pkg::*;

  localparam int W    = 8;
  localparam int FCLK = 16000000;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk       = 1'b0;
  logic         rstn      = 1'b0;
  logic         serial_in = 1'b1;
  baud_set_t    baud      = BAUD_115200;
  logic [W-1:0] data_out;
  logic         rx_valid;
  logic         frame_err;
  logic         parity_err;
  logic         rx_busy;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  cyc   = 0;
  logic [W-1:0] last_d = '0;

  typedef struct {
    int unsigned  t;
    logic         v;
    logic         f;
    logic         p;
    logic [W-1:0] d;
  } ev_t;

  typedef struct {
    int unsigned  lo;
    int unsigned  hi;
    logic         v;
    logic         f;
    logic         p;
    logic [W-1:0] d;
  } exp_t;

  ev_t  got_q[$];
  exp_t exp_q[$];

  uart_rx_controller #(
    .OUTPUT_DATA_WIDTH(W),
    .F_CLK            (FCLK)
  ) dut (
    .clk_16mhz   (clk),
    .rstn        (rstn),
    .serial_in   (serial_in),
    .baud_setting(baud),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with any pulse high is one event; a stretched pulse shows up twice
  always @(negedge clk)
    if (rx_valid || frame_err || parity_err)
      got_q.push_back('{cyc, rx_valid, frame_err, parity_err, data_out});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned div_of(input baud_set_t b);
    int unsigned rate;
    case (b)
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_57600:  rate = 57600;
      default:     rate = 115200;
    endcase
    return (FCLK + 8 * rate) / (16 * rate);
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ideal frame; expected pulse lands about 9.5/16 into the stop bit plus 3 sync cycles
  task automatic send(input logic [W-1:0] d, input logic par_ok, input logic stop_ok,
                      input logic chg_baud);
    int unsigned dv, bl, stop_at;
    logic        par;
    dv      = div_of(baud);
    bl      = 16 * dv;
    par     = par_ok ? (^d) : ~(^d);
    stop_at = cyc + (1 + W + P) * bl;
    exp_q.push_back('{stop_at + 8 * dv + 3, stop_at + 11 * dv + 3,
                      stop_ok, !stop_ok, (P == 1) && !par_ok, d});
    last_d = d;
    serial_in = 1'b0;
    tick(bl);
    if (chg_baud) baud = baud_set_t'($urandom_range(2, 3));
    for (int i = 0; i < W; i++) begin
      serial_in = d[i];
      tick(bl);
    end
    if (P == 1) begin
      serial_in = par;
      tick(bl);
    end
    serial_in = stop_ok;
    tick(bl);
    serial_in = 1'b1;
  endtask

  task automatic drain(input string tag);
    ev_t  g;
    exp_t e;
    tick(4);
    check({tag, "_events"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_when"},   32'(g.t >= e.lo && g.t <= e.hi), 32'd1);
      check({tag, "_valid"},  32'(g.v), 32'(e.v));
      check({tag, "_ferr"},   32'(g.f), 32'(e.f));
      check({tag, "_perr"},   32'(g.p), 32'(e.p));
      check({tag, "_data"},   32'(g.d), 32'(e.d));
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int unsigned bl;
    logic [W-1:0] d;

    tick(3);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_valid", 32'(rx_valid),   32'd0);
    check("rst_ferr",  32'(frame_err),  32'd0);
    check("rst_perr",  32'(parity_err), 32'd0);
    check("rst_busy",  32'(rx_busy),    32'd0);
    rstn = 1'b1;
    tick(20);

    baud = BAUD_9600;
    tick(2);
    check("div9600", div_of(baud), 32'd104);
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    drain("a5");
    check("a5_out", 32'(data_out), 32'hA5);

    baud = BAUD_57600;
    tick(2);
    send(8'h00, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b1, 1'b0);
    drain("b2b");

    baud = BAUD_115200;
    bl   = 16 * div_of(baud);
    tick(bl);
    serial_in = 1'b0;
    tick(bl * 4 / 10);
    serial_in = 1'b1;
    tick(bl);
    drain("glitch");
    check("glitch_hold", 32'(data_out), 32'(last_d));

    send(8'h55, 1'b1, 1'b0, 1'b0);
    tick(20);
    send(8'h12, 1'b1, 1'b1, 1'b0);
    drain("ferr");

    d = 8'h81;
    tick(bl);
    serial_in = 1'b0;
    tick(bl);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      tick(bl);
    end
    serial_in = d[4];
    tick(bl / 2);
    rstn = 1'b0;
    #1;
    check("mid_rst_data",  32'(data_out),   32'd0);
    check("mid_rst_valid", 32'(rx_valid),   32'd0);
    check("mid_rst_ferr",  32'(frame_err),  32'd0);
    check("mid_rst_busy",  32'(rx_busy),    32'd0);
    serial_in = 1'b1;
    tick(10);
    rstn = 1'b1;
    tick(bl);
    drain("rst_abort");
    send(8'h7E, 1'b1, 1'b1, 1'b0);
    drain("after_rst");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1, 1'b0);
    drain("par");
`endif

    for (int n = 0; n < 10; n++) begin
      baud = baud_set_t'($urandom_range(2, 3));
      bl   = 16 * div_of(baud);
      tick(8 + $urandom_range(0, bl));
      send(W'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 2) == 0));
      tick(8);
      drain("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
